// File: rtl/fh_rom_arb_pkg.sv
// Shared types and defaults for the font/marker ROM burst arbiter.
// Widths default to the 256 x 96 fh_rom with a single-cycle read.
package fh_rom_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 96;
   localparam int DEF_LEN_WIDTH  = 4;
   localparam int DEF_ROM_LAT    = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   // Tag carried alongside each ROM read until its data comes back.
   typedef struct packed {
      logic valid;
      logic id;
      logic last;
   } rsp_tag_t;

endpackage

// File: rtl/fh_rom_rsp_pipe.sv
// Delay line matching the ROM read latency; carries {valid, id, last}
// so each returning word is tagged with its owner. Cleared by srst.
module fh_rom_rsp_pipe
   import fh_rom_arb_pkg::*;
#(
   parameter int LAT = DEF_ROM_LAT
) (
   input  logic     clk,
   input  logic     srst,
   input  rsp_tag_t in_tag,
   output rsp_tag_t out_tag
);

   rsp_tag_t stage_reg [LAT];

   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (srst) begin
               stage_reg[gi] <= '0;
            end else if (gi == 0) begin
               stage_reg[gi] <= in_tag;
            end else begin
               stage_reg[gi] <= stage_reg[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
   endgenerate

   assign out_tag = stage_reg[LAT-1];

endmodule

// File: rtl/fh_rom_burst_arb.sv
// Round-robin burst arbiter sharing the single-port fh_rom between the text
// overlay (req 0) and the marker overlay (req 1).
module fh_rom_burst_arb
   import fh_rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int ROM_LAT    = DEF_ROM_LAT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*LEN_WIDTH-1:0]  req_len,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_last,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   rom_addr,
   input  logic [DATA_WIDTH-1:0]   rom_rd_data
);

   localparam int DRAIN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   arb_state_t             state_reg, state_next;
   logic                   ptr_reg;
   logic                   id_reg;
   logic [LEN_WIDTH-1:0]   len_cnt_reg;
   logic [ADDR_WIDTH-1:0]  addr_reg;
   logic [DRAIN_W-1:0]     drain_reg;

   logic                   gnt_id;
   logic                   any_req;
   logic                   issue_last;
   logic [ADDR_WIDTH-1:0]  gnt_addr;
   logic [LEN_WIDTH-1:0]   gnt_len;
   rsp_tag_t               pipe_in, pipe_out;

   // The pointer only decides when both request; a lone requester always wins.
   assign any_req    = |req_valid;
   assign gnt_id     = req_valid[ptr_reg] ? ptr_reg : ~ptr_reg;
   assign gnt_addr   = gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
   assign gnt_len    = gnt_id ? req_len[2*LEN_WIDTH-1:LEN_WIDTH] : req_len[LEN_WIDTH-1:0];
   assign issue_last = (state_reg == ISSUE) && (len_cnt_reg == '0);

   always_comb begin
      state_next = state_reg;
      req_ready  = 2'b00;
      case (state_reg)
         IDLE: begin
            if (any_req && !rst) begin
               req_ready  = gnt_id ? 2'b10 : 2'b01;
            end
            if (any_req) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (len_cnt_reg == '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_reg == '0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         ptr_reg     <= 1'b0;
         id_reg      <= 1'b0;
         len_cnt_reg <= '0;
         addr_reg    <= '0;
         drain_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  id_reg      <= gnt_id;
                  ptr_reg     <= ~gnt_id;
                  addr_reg    <= gnt_addr;
                  len_cnt_reg <= gnt_len;
               end
            end
            ISSUE: begin
               // Address stays on the final word so rom_addr holds through DRAIN/IDLE.
               if (len_cnt_reg == '0) begin
                  drain_reg <= DRAIN_W'(ROM_LAT - 1);
               end else begin
                  len_cnt_reg <= len_cnt_reg - 1'b1;
                  addr_reg    <= addr_reg + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_reg != '0) begin
                  drain_reg <= drain_reg - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pipe_in.valid = (state_reg == ISSUE);
   assign pipe_in.id    = id_reg;
   assign pipe_in.last  = issue_last;

   fh_rom_rsp_pipe #(
      .LAT (ROM_LAT)
   ) u_rsp_pipe (
      .clk     (clk),
      .srst    (rst),
      .in_tag  (pipe_in),
      .out_tag (pipe_out)
   );

   assign rsp_valid = {pipe_out.valid & pipe_out.id, pipe_out.valid & ~pipe_out.id};
   assign rsp_last  = pipe_out.valid & pipe_out.last;
   assign rsp_data  = rom_rd_data;
   assign busy      = (state_reg != IDLE);
   assign rom_addr  = addr_reg;

endmodule
